e203_exu_alu_rglr_buf: RTL and testbench



---
 rtl/e203_exu_alu_rglr_buf.sv | 172 +++++++++++++++++
 tb/tb_e203_exu_alu_rglr_buf.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_alu_rglr_buf.sv
// Regular-ALU issue unit: decodes the info bus, drives the shared ALU datapath and
// queues results for commit. Optional same-cycle bypass: E203_ALU_RGLR_BYPASS_EN.
module e203_exu_alu_rglr_buf #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             alu_i_valid,
  output logic             alu_i_ready,
  input  logic [XLEN-1:0]  alu_i_rs1,
  input  logic [XLEN-1:0]  alu_i_rs2,
  input  logic [XLEN-1:0]  alu_i_imm,
  input  logic [XLEN-1:0]  alu_i_pc,
  input  logic [20:0]      alu_i_info,

  input  logic             alu_flush,

  output logic             alu_o_valid,
  input  logic             alu_o_ready,
  output logic [XLEN-1:0]  alu_o_wbck_wdat,
  output logic             alu_o_wbck_err,
  output logic             alu_o_cmt_ecall,
  output logic             alu_o_cmt_ebreak,
  output logic             alu_o_cmt_wfi,
  output logic [CNT_W-1:0] alu_o_pend_cnt,

  output logic             alu_req_alu_add,
  output logic             alu_req_alu_sub,
  output logic             alu_req_alu_xor,
  output logic             alu_req_alu_sll,
  output logic             alu_req_alu_srl,
  output logic             alu_req_alu_sra,
  output logic             alu_req_alu_or,
  output logic             alu_req_alu_and,
  output logic             alu_req_alu_slt,
  output logic             alu_req_alu_sltu,
  output logic             alu_req_alu_lui,
  output logic [XLEN-1:0]  alu_req_alu_op1,
  output logic [XLEN-1:0]  alu_req_alu_op2,
  input  logic [XLEN-1:0]  alu_req_alu_res
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Info bus field positions
  localparam int unsigned I_ADD    = 4;
  localparam int unsigned I_SUB    = 5;
  localparam int unsigned I_XOR    = 6;
  localparam int unsigned I_SLL    = 7;
  localparam int unsigned I_SRL    = 8;
  localparam int unsigned I_SRA    = 9;
  localparam int unsigned I_OR     = 10;
  localparam int unsigned I_AND    = 11;
  localparam int unsigned I_SLT    = 12;
  localparam int unsigned I_SLTU   = 13;
  localparam int unsigned I_LUI    = 14;
  localparam int unsigned I_OP2IMM = 15;
  localparam int unsigned I_OP1PC  = 16;
  localparam int unsigned I_NOP    = 17;
  localparam int unsigned I_ECALL  = 18;
  localparam int unsigned I_EBREAK = 19;
  localparam int unsigned I_WFI    = 20;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            ecall;
    logic            ebreak;
    logic            wfi;
  } ent_t;

  ent_t             mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;

  logic empty_c;
  logic full_c;
  logic byp_c;
  logic push_c;
  logic pop_c;
  ent_t in_ent_c;
  ent_t head_c;
  ent_t out_ent_c;

  // Bits [3:0] carry the dispatch group tag and are not needed here
  logic unused_info;
  assign unused_info = ^alu_i_info[3:0];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Datapath request decode, independent of valid
  assign alu_req_alu_add  = alu_i_info[I_ADD] & ~alu_i_info[I_NOP];
  assign alu_req_alu_sub  = alu_i_info[I_SUB];
  assign alu_req_alu_xor  = alu_i_info[I_XOR];
  assign alu_req_alu_sll  = alu_i_info[I_SLL];
  assign alu_req_alu_srl  = alu_i_info[I_SRL];
  assign alu_req_alu_sra  = alu_i_info[I_SRA];
  assign alu_req_alu_or   = alu_i_info[I_OR];
  assign alu_req_alu_and  = alu_i_info[I_AND];
  assign alu_req_alu_slt  = alu_i_info[I_SLT];
  assign alu_req_alu_sltu = alu_i_info[I_SLTU];
  assign alu_req_alu_lui  = alu_i_info[I_LUI];

  assign alu_req_alu_op1 = alu_i_info[I_OP1PC]  ? alu_i_pc  : alu_i_rs1;
  assign alu_req_alu_op2 = alu_i_info[I_OP2IMM] ? alu_i_imm : alu_i_rs2;

  assign in_ent_c = '{res:    alu_req_alu_res,
                      ecall:  alu_i_info[I_ECALL],
                      ebreak: alu_i_info[I_EBREAK],
                      wfi:    alu_i_info[I_WFI]};

  assign empty_c = (cnt == '0);
  assign full_c  = (cnt == CNT_W'(DEPTH));

`ifdef E203_ALU_RGLR_BYPASS_EN
  assign byp_c = empty_c & alu_i_valid & alu_o_ready & ~alu_flush;
`else
  assign byp_c = 1'b0;
`endif

  // Ready depends only on queue state and flush, never on the consumer
  assign alu_i_ready = ~full_c & ~alu_flush;
  assign push_c      = alu_i_valid & alu_i_ready & ~byp_c;
  assign pop_c       = ~empty_c & alu_o_ready;

  assign alu_o_valid = ~empty_c | byp_c;
  assign head_c      = byp_c ? in_ent_c : mem[rptr];
  assign out_ent_c   = alu_o_valid ? head_c : '0;

  assign alu_o_wbck_wdat  = out_ent_c.res;
  assign alu_o_cmt_ecall  = out_ent_c.ecall;
  assign alu_o_cmt_ebreak = out_ent_c.ebreak;
  assign alu_o_cmt_wfi    = out_ent_c.wfi;
  assign alu_o_wbck_err   = out_ent_c.ecall | out_ent_c.ebreak | out_ent_c.wfi;
  assign alu_o_pend_cnt   = cnt;

  // Pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (alu_flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_c) wptr <= ptr_inc(wptr);
      if (pop_c)  rptr <= ptr_inc(rptr);
      case ({push_c, pop_c})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_c) begin
      mem[wptr] <= in_ent_c;
    end
  end

endmodule

// File: tb/tb_e203_exu_alu_rglr_buf.sv
// Scoreboard bench for e203_exu_alu_rglr_buf: a DEPTH=2 instance for the main
// scenarios and a DEPTH=1 instance for the throughput/bypass scenario.
module tb_e203_exu_alu_rglr_buf;

`ifdef E203_ALU_RGLR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic        ecall;
    logic        ebreak;
    logic        wfi;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic        a_valid = 0, a_oready = 0, a_flush = 0;
  logic [31:0] a_rs1 = 0, a_rs2 = 0, a_imm = 0, a_pc = 0, a_res = 0;
  logic [20:0] a_info = 0;
  logic        a_ready, a_ovalid, a_err, a_ecall, a_ebreak, a_wfi;
  logic [31:0] a_wdat, a_op1, a_op2;
  logic [1:0]  a_cnt;
  logic a_add, a_sub, a_xor, a_sll, a_srl, a_sra, a_or, a_and, a_slt, a_sltu, a_lui;
  wire [10:0] a_ops = {a_lui, a_sltu, a_slt, a_and, a_or, a_sra, a_srl, a_sll, a_xor, a_sub, a_add};

  e203_exu_alu_rglr_buf #(.XLEN(32), .DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .alu_i_valid(a_valid), .alu_i_ready(a_ready),
    .alu_i_rs1(a_rs1), .alu_i_rs2(a_rs2), .alu_i_imm(a_imm), .alu_i_pc(a_pc),
    .alu_i_info(a_info), .alu_flush(a_flush),
    .alu_o_valid(a_ovalid), .alu_o_ready(a_oready),
    .alu_o_wbck_wdat(a_wdat), .alu_o_wbck_err(a_err),
    .alu_o_cmt_ecall(a_ecall), .alu_o_cmt_ebreak(a_ebreak), .alu_o_cmt_wfi(a_wfi),
    .alu_o_pend_cnt(a_cnt),
    .alu_req_alu_add(a_add), .alu_req_alu_sub(a_sub), .alu_req_alu_xor(a_xor),
    .alu_req_alu_sll(a_sll), .alu_req_alu_srl(a_srl), .alu_req_alu_sra(a_sra),
    .alu_req_alu_or(a_or), .alu_req_alu_and(a_and), .alu_req_alu_slt(a_slt),
    .alu_req_alu_sltu(a_sltu), .alu_req_alu_lui(a_lui),
    .alu_req_alu_op1(a_op1), .alu_req_alu_op2(a_op2), .alu_req_alu_res(a_res)
  );

  // DEPTH=1 instance
  logic        b_valid = 0, b_oready = 0, b_flush = 0;
  logic [31:0] b_res = 0;
  logic [20:0] b_info = 21'h10;
  logic        b_ready, b_ovalid, b_err, b_ecall, b_ebreak, b_wfi;
  logic [31:0] b_wdat, b_op1, b_op2;
  logic [0:0]  b_cnt;
  logic b_add, b_sub, b_xor, b_sll, b_srl, b_sra, b_or, b_and, b_slt, b_sltu, b_lui;

  e203_exu_alu_rglr_buf #(.XLEN(32), .DEPTH(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .alu_i_valid(b_valid), .alu_i_ready(b_ready),
    .alu_i_rs1(a_rs1), .alu_i_rs2(a_rs2), .alu_i_imm(a_imm), .alu_i_pc(a_pc),
    .alu_i_info(b_info), .alu_flush(b_flush),
    .alu_o_valid(b_ovalid), .alu_o_ready(b_oready),
    .alu_o_wbck_wdat(b_wdat), .alu_o_wbck_err(b_err),
    .alu_o_cmt_ecall(b_ecall), .alu_o_cmt_ebreak(b_ebreak), .alu_o_cmt_wfi(b_wfi),
    .alu_o_pend_cnt(b_cnt),
    .alu_req_alu_add(b_add), .alu_req_alu_sub(b_sub), .alu_req_alu_xor(b_xor),
    .alu_req_alu_sll(b_sll), .alu_req_alu_srl(b_srl), .alu_req_alu_sra(b_sra),
    .alu_req_alu_or(b_or), .alu_req_alu_and(b_and), .alu_req_alu_slt(b_slt),
    .alu_req_alu_sltu(b_sltu), .alu_req_alu_lui(b_lui),
    .alu_req_alu_op1(b_op1), .alu_req_alu_op2(b_op2), .alu_req_alu_res(b_res)
  );

  exp_t qa[$];
  exp_t qb[$];

  // Scoreboard for instance A: expectations pushed on accept, compared on commit
  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    if (!rst_n) begin
      qa.delete();
    end else begin
      exp_v = (qa.size() != 0) || (BYP && a_valid && a_oready && !a_flush);
      checks++;
      if (a_ovalid !== exp_v) begin
        failures++; $display("FAIL a_valid: got %b want %b @%0t", a_ovalid, exp_v, $time);
      end
      checks++;
      if (a_cnt !== 2'(qa.size())) begin
        failures++; $display("FAIL a_pend_cnt: got %0d want %0d @%0t", a_cnt, qa.size(), $time);
      end
      checks++;
      if (a_ready !== (qa.size() < 2 && !a_flush)) begin
        failures++; $display("FAIL a_i_ready: got %b qsize %0d flush %b @%0t", a_ready, qa.size(), a_flush, $time);
      end
      if (!a_ovalid) begin
        checks++;
        if ({a_wdat, a_err, a_ecall, a_ebreak, a_wfi} !== 36'h0) begin
          failures++; $display("FAIL a_mask: got wdat %h flags %b%b%b%b @%0t", a_wdat, a_err, a_ecall, a_ebreak, a_wfi, $time);
        end
      end
      if (a_valid && a_ready && !a_flush)
        qa.push_back('{res: a_res, ecall: a_info[18], ebreak: a_info[19], wfi: a_info[20]});
      if (a_ovalid && a_oready) begin
        checks++;
        if (qa.size() == 0) begin
          failures++; $display("FAIL a_commit: unexpected commit wdat %h @%0t", a_wdat, $time);
        end else begin
          e = qa.pop_front();
          if ({a_wdat, a_ecall, a_ebreak, a_wfi, a_err} !==
              {e.res, e.ecall, e.ebreak, e.wfi, e.ecall | e.ebreak | e.wfi}) begin
            failures++; $display("FAIL a_commit: got %h/%b%b%b err %b want %h/%b%b%b @%0t",
              a_wdat, a_ecall, a_ebreak, a_wfi, a_err, e.res, e.ecall, e.ebreak, e.wfi, $time);
          end
        end
      end
      if (a_flush) qa.delete();
    end
  end

  // Scoreboard for instance B
  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    if (!rst_n) begin
      qb.delete();
    end else begin
      exp_v = (qb.size() != 0) || (BYP && b_valid && b_oready);
      checks++;
      if (b_ovalid !== exp_v) begin
        failures++; $display("FAIL b_valid: got %b want %b @%0t", b_ovalid, exp_v, $time);
      end
      checks++;
      if (b_cnt !== 1'(qb.size())) begin
        failures++; $display("FAIL b_pend_cnt: got %0d want %0d @%0t", b_cnt, qb.size(), $time);
      end
      if (b_valid && b_ready) qb.push_back('{res: b_res, ecall: 1'b0, ebreak: 1'b0, wfi: 1'b0});
      if (b_ovalid && b_oready) begin
        checks++;
        if (qb.size() == 0) begin
          failures++; $display("FAIL b_commit: unexpected commit wdat %h @%0t", b_wdat, $time);
        end else begin
          e = qb.pop_front();
          if (b_wdat !== e.res) begin
            failures++; $display("FAIL b_commit: got %h want %h @%0t", b_wdat, e.res, $time);
          end
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({a_ovalid, a_cnt, a_ready, a_wdat} !== {1'b0, 2'd0, 1'b1, 32'h0}) begin
      failures++; $display("FAIL reset_state: valid %b cnt %0d ready %b wdat %h", a_ovalid, a_cnt, a_ready, a_wdat);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    next_cyc();
  endtask

  task automatic test_decode();
    a_valid = 0;
    for (int i = 4; i <= 14; i++) begin
      a_info = 21'(1) << i;
      #1;
      checks++;
      if (a_ops !== 11'(11'(1) << (i - 4))) begin
        failures++; $display("FAIL decode_bit%0d: got %b want %b", i, a_ops, 11'(11'(1) << (i - 4)));
      end
    end
    a_rs1 = 32'h1000; a_pc = 32'h2000; a_rs2 = 32'h3000; a_imm = 32'h4000;
    for (int k = 0; k < 4; k++) begin
      a_info = 21'(k) << 15;
      #1;
      checks++;
      if ({a_op1, a_op2} !== {(k[1] ? 32'h2000 : 32'h1000), (k[0] ? 32'h4000 : 32'h3000)}) begin
        failures++; $display("FAIL operand_sel%0d: got op1 %h op2 %h", k, a_op1, a_op2);
      end
    end
    a_info = 0;
    next_cyc();
  endtask

  task automatic test_basic_push();
    a_oready = 0;
    a_valid = 1; a_rs1 = 5; a_rs2 = 99; a_imm = 3; a_pc = 0;
    a_info = 21'h10 | 21'h8000; a_res = 8;
    @(negedge clk);
    checks++;
    if ({a_op1, a_op2, a_add} !== {32'd5, 32'd3, 1'b1}) begin
      failures++; $display("FAIL addi_req: got op1 %0d op2 %0d add %b", a_op1, a_op2, a_add);
    end
    next_cyc();
    a_valid = 0; a_info = 0;
    @(negedge clk);
    checks++;
    if ({a_ovalid, a_wdat, a_err} !== {1'b1, 32'd8, 1'b0}) begin
      failures++; $display("FAIL addi_head: got valid %b wdat %0d err %b", a_ovalid, a_wdat, a_err);
    end
    next_cyc();
    a_oready = 1;
    next_cyc();
    a_oready = 0;
  endtask

  task automatic test_back_pressure();
    logic got;
    a_oready = 0; a_valid = 1; a_info = 21'h10;
    a_res = 32'h11; next_cyc();
    a_res = 32'h22; next_cyc();
    a_res = 32'h33;
    @(negedge clk);
    checks++;
    if ({a_ready, a_cnt} !== {1'b0, 2'd2}) begin
      failures++; $display("FAIL bp_full: got ready %b cnt %0d want ready 0 cnt 2", a_ready, a_cnt);
    end
    next_cyc();
    a_oready = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (a_ready) got = 1;
      next_cyc();
    end
    a_valid = 0;
    checks++;
    if (!got) begin
      failures++; $display("FAIL bp_resume: got no accept want 0x33 accepted within 10 cycles");
    end
    repeat (3) next_cyc();
    a_oready = 0;
  endtask

  task automatic test_flags();
    logic [20:0] infos [4];
    logic [2:0]  flags [4];
    infos[0] = 21'h10 | 21'h20000; flags[0] = 3'b000;
    infos[1] = 21'h40000;          flags[1] = 3'b100;
    infos[2] = 21'h100000;         flags[2] = 3'b001;
    infos[3] = 21'h80000;          flags[3] = 3'b010;
    a_oready = 0;
    for (int k = 0; k < 4; k++) begin
      a_valid = 1; a_info = infos[k]; a_res = 32'hA0 + 32'(k);
      @(negedge clk);
      if (k == 0) begin
        checks++;
        if (a_add !== 1'b0) begin
          failures++; $display("FAIL nop_add: got %b want 0", a_add);
        end
      end
      next_cyc();
      a_valid = 0; a_info = 0;
      @(negedge clk);
      checks++;
      if ({a_ecall, a_ebreak, a_wfi, a_err} !== {flags[k], |flags[k]}) begin
        failures++; $display("FAIL flags%0d: got %b%b%b err %b want %b err %b",
          k, a_ecall, a_ebreak, a_wfi, a_err, flags[k], |flags[k]);
      end
      next_cyc();
      a_oready = 1;
      next_cyc();
      a_oready = 0;
    end
  endtask

  task automatic test_flush();
    a_oready = 0; a_valid = 1; a_info = 21'h10;
    a_res = 32'h44; next_cyc();
    a_res = 32'h55; next_cyc();
    a_flush = 1; a_res = 32'h77;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b0) begin
      failures++; $display("FAIL flush_ready: got %b want 0", a_ready);
    end
    next_cyc();
    a_flush = 0;
    @(negedge clk);
    checks++;
    if ({a_ovalid, a_cnt, a_ready} !== {1'b0, 2'd0, 1'b1}) begin
      failures++; $display("FAIL flush_clear: got valid %b cnt %0d ready %b", a_ovalid, a_cnt, a_ready);
    end
    next_cyc();
    a_valid = 0;
    @(negedge clk);
    checks++;
    if ({a_ovalid, a_wdat} !== {1'b1, 32'h77}) begin
      failures++; $display("FAIL flush_after: got valid %b wdat %h want 1 77", a_ovalid, a_wdat);
    end
    next_cyc();
    a_oready = 1;
    next_cyc();
    a_oready = 0;
  endtask

  task automatic test_reset_midstream();
    a_oready = 0; a_valid = 1; a_info = 21'h10;
    a_res = 32'h66; next_cyc();
    a_res = 32'h67; next_cyc();
    a_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_ovalid, a_cnt, a_ready, a_wdat} !== {1'b0, 2'd0, 1'b1, 32'h0}) begin
      failures++; $display("FAIL midstream_reset: valid %b cnt %0d ready %b wdat %h", a_ovalid, a_cnt, a_ready, a_wdat);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    next_cyc();
  endtask

  task automatic test_depth1();
    int acc;
    acc = 0;
    b_valid = 1; b_oready = 1;
    for (int i = 0; i < 8; i++) begin
      b_res = 32'h100 + 32'(i);
      @(negedge clk);
      if (b_ready) acc++;
      if (BYP) begin
        checks++;
        if ({b_ovalid, b_wdat} !== {1'b1, b_res}) begin
          failures++; $display("FAIL d1_bypass%0d: got valid %b wdat %h want 1 %h", i, b_ovalid, b_wdat, b_res);
        end
      end
      next_cyc();
    end
    b_valid = 0;
    checks++;
    if (acc !== (BYP ? 8 : 4)) begin
      failures++; $display("FAIL d1_rate: got %0d accepts want %0d", acc, BYP ? 8 : 4);
    end
    repeat (2) next_cyc();
    b_oready = 0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_basic_push();
    test_back_pressure();
    test_flags();
    test_flush();
    test_reset_midstream();
    test_depth1();
    repeat (2) next_cyc();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++; $display("FAIL drain: got %0d/%0d entries left want 0/0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
